// File: rtl/seg_pkg.sv
// Shared segment patterns and select helpers for the 7-segment display blocks.
// Segment bytes are active-high: bit7 = dp, bits6..0 = g..a.
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // All-deselected pattern for an active-low select bus of width w.
    function automatic logic [MAX_DIGITS-1:0] cs_none(input int unsigned w);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            if (k < w) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to 7-segment decoder (g..a, active-high).
// In decimal mode values 10..15 decode to dark.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_mode_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK[6:0];
        case (nibble_i)
            4'h0:    seg_o = SEG_0[6:0];
            4'h1:    seg_o = SEG_1[6:0];
            4'h2:    seg_o = SEG_2[6:0];
            4'h3:    seg_o = SEG_3[6:0];
            4'h4:    seg_o = SEG_4[6:0];
            4'h5:    seg_o = SEG_5[6:0];
            4'h6:    seg_o = SEG_6[6:0];
            4'h7:    seg_o = SEG_7[6:0];
            4'h8:    seg_o = SEG_8[6:0];
            4'h9:    seg_o = SEG_9[6:0];
            4'hA:    seg_o = SEG_A[6:0];
            4'hB:    seg_o = SEG_B[6:0];
            4'hC:    seg_o = SEG_C[6:0];
            4'hD:    seg_o = SEG_D[6:0];
            4'hE:    seg_o = SEG_E[6:0];
            4'hF:    seg_o = SEG_F[6:0];
            default: seg_o = SEG_BLANK[6:0];
        endcase
        if (!hex_mode_i && nibble_i > 4'd9) seg_o = SEG_BLANK[6:0];
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-cathode 7-segment scan driver with dead time,
// blanking, blinking, decimal points and a per-frame input snapshot.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 200,
    parameter int unsigned DEAD_CYCLES  = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] Digit_Data,
    input  logic [NUM_DIGITS-1:0]   Dp_Mask,
    input  logic [NUM_DIGITS-1:0]   Blank_Mask,
    input  logic [NUM_DIGITS-1:0]   Blink_Mask,
    input  logic                    Hex_Mode,
    output logic [7:0]              Digitron_Out,
    output logic [NUM_DIGITS-1:0]   DigitronCS_Out,
    output logic                    Frame_Pulse
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [CW:0]   DEAD_W   = (CW + 1)'(DEAD_CYCLES);

    localparam logic [MAX_DIGITS-1:0] CS_FULL = cs_none(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] CS_ALL  = CS_FULL[NUM_DIGITS-1:0];

    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic                    snap_hex_q, snap_hex_d;
    logic                    snap_phase_q, snap_phase_d;

    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] cs_q, cs_d;
    logic                  fp_q, fp_d;

    logic                    frame_start;
    logic [4*NUM_DIGITS-1:0] eff_data;
    logic [NUM_DIGITS-1:0]   eff_dp, eff_blank, eff_blink;
    logic                    eff_hex, eff_phase;

    logic [3:0]            nib;
    logic                  cur_dp, cur_blank, cur_blink;
    logic [NUM_DIGITS-1:0] sel_oh;
    logic [6:0]            dec_seg;
    logic                  dark;

    assign frame_start = (count_q == '0) && (idx_q == '0);

    // The frame's first slot is rendered from the values being captured,
    // so every slot of a frame sees one consistent input set.
    assign eff_data  = frame_start ? Digit_Data : snap_data_q;
    assign eff_dp    = frame_start ? Dp_Mask    : snap_dp_q;
    assign eff_blank = frame_start ? Blank_Mask : snap_blank_q;
    assign eff_blink = frame_start ? Blink_Mask : snap_blink_q;
    assign eff_hex   = frame_start ? Hex_Mode   : snap_hex_q;
    assign eff_phase = frame_start ? phase_q    : snap_phase_q;

    always_comb begin
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        sel_oh    = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IW'(k)) begin
                nib       = eff_data[4*k +: 4];
                cur_dp    = eff_dp[k];
                cur_blank = eff_blank[k];
                cur_blink = eff_blink[k];
                sel_oh[k] = 1'b1;
            end
        end
    end

    seg7_decode u_dec (
        .nibble_i   (nib),
        .hex_mode_i (eff_hex),
        .seg_o      (dec_seg)
    );

    always_comb begin
        count_d = count_q + CW'(1);
        idx_d   = idx_q;
        if (count_q == CNT_LAST) begin
            count_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        bcnt_d       = bcnt_q;
        phase_d      = phase_q;
        snap_data_d  = snap_data_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        snap_blink_d = snap_blink_q;
        snap_hex_d   = snap_hex_q;
        snap_phase_d = snap_phase_q;
        if (frame_start) begin
            snap_data_d  = Digit_Data;
            snap_dp_d    = Dp_Mask;
            snap_blank_d = Blank_Mask;
            snap_blink_d = Blink_Mask;
            snap_hex_d   = Hex_Mode;
            snap_phase_d = phase_q;
            if (bcnt_q == BLK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        dark = ({1'b0, count_q} < DEAD_W) || cur_blank
            || (cur_blink && eff_phase);
        seg_d = dark ? SEG_BLANK : {cur_dp, dec_seg};
        cs_d  = dark ? CS_ALL : ~sel_oh;
        fp_d  = frame_start;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q      <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            phase_q      <= 1'b0;
            snap_data_q  <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            snap_blink_q <= '0;
            snap_hex_q   <= 1'b0;
            snap_phase_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            cs_q         <= CS_ALL;
            fp_q         <= 1'b0;
        end else begin
            count_q      <= count_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
            snap_data_q  <= snap_data_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            snap_blink_q <= snap_blink_d;
            snap_hex_q   <= snap_hex_d;
            snap_phase_q <= snap_phase_d;
            seg_q        <= seg_d;
            cs_q         <= cs_d;
            fp_q         <= fp_d;
        end
    end

    assign Digitron_Out   = seg_q;
    assign DigitronCS_Out = cs_q;
    assign Frame_Pulse    = fp_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: vector table, directed corner sequences and
// randomized inputs checked against a frame-level reference model.
module tb_seg_scan_display;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int D  = 2;
    localparam int BF = 2;
    localparam int FL = N * S;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [15:0]   data = '0;
    logic [3:0]    dp = '0, blank = '0, blink = '0;
    logic          hex = 1'b0;
    logic [7:0]    seg;
    logic [3:0]    cs;
    logic          fp;

    logic          RST2 = 1'b1;
    logic [3:0]    data2 = 4'h5;
    logic [0:0]    dp2 = 1'b0, blank2 = 1'b0, blink2 = 1'b0;
    logic [7:0]    seg2;
    logic [0:0]    cs2;
    logic          fp2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    seg_scan_display #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(D), .BLINK_FRAMES(BF)
    ) dut (
        .CLK(CLK), .RST(RST), .Digit_Data(data), .Dp_Mask(dp),
        .Blank_Mask(blank), .Blink_Mask(blink), .Hex_Mode(hex),
        .Digitron_Out(seg), .DigitronCS_Out(cs), .Frame_Pulse(fp)
    );

    seg_scan_display #(
        .NUM_DIGITS(1), .SCAN_DIV(2), .DEAD_CYCLES(0), .BLINK_FRAMES(2)
    ) dut2 (
        .CLK(CLK), .RST(RST2), .Digit_Data(data2), .Dp_Mask(dp2),
        .Blank_Mask(blank2), .Blink_Mask(blink2), .Hex_Mode(1'b0),
        .Digitron_Out(seg2), .DigitronCS_Out(cs2), .Frame_Pulse(fp2)
    );

    // Reference segment table, indexed by nibble value.
    logic [7:0] pat [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
        8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Model: n counts cycles since reset release; frame inputs are
    // latched whenever n lands on a frame boundary.
    int         n = 0;
    logic [15:0] f_data;
    logic [3:0]  f_dp, f_blank, f_blink;
    logic        f_hex, f_phase;
    logic [7:0]  e_seg;
    logic [3:0]  e_cs;
    logic        e_fp;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    task automatic step();
        int c, i;
        logic [3:0] nb;
        bit dk;
        @(posedge CLK);
        if (RST) begin
            e_seg = 8'h00; e_cs = 4'hF; e_fp = 1'b0; n = 0;
        end else begin
            c = n % S;
            i = (n / S) % N;
            if (n % FL == 0) begin
                f_data = data; f_dp = dp; f_blank = blank;
                f_blink = blink; f_hex = hex;
                f_phase = ((n / FL) / BF) % 2 == 1;
            end
            e_fp = (n % FL == 0);
            dk = (c < D) || f_blank[i] || (f_blink[i] && f_phase);
            nb = f_data[4*i +: 4];
            if (dk) begin
                e_seg = 8'h00; e_cs = 4'hF;
            end else begin
                e_seg = (!f_hex && nb > 9) ? 8'h00 : pat[nb];
                e_seg[7] = f_dp[i];
                e_cs = 4'hF;
                e_cs[i] = 1'b0;
            end
            n++;
        end
        @(negedge CLK);
        chk("seg", 32'(seg), 32'(e_seg));
        chk("cs", 32'(cs), 32'(e_cs));
        chk("frame_pulse", 32'(fp), 32'(e_fp));
        chk("cs_one_low", 32'($countones(~cs) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp, blank, blink;
        logic        hex;
        int          dig;
        logic [7:0]  seg;
        logic [3:0]  cs;
    } vec_t;

    vec_t vt [14];

    initial begin
        int fp_at [$];
        int cnt, bad;

        vt[0]  = '{16'h4321, 4'h0, 4'h0, 4'h0, 1'b0, 0, 8'h06, 4'hE};
        vt[1]  = '{16'h4321, 4'h0, 4'h0, 4'h0, 1'b0, 1, 8'h5B, 4'hD};
        vt[2]  = '{16'h4321, 4'h0, 4'h0, 4'h0, 1'b0, 3, 8'h66, 4'h7};
        vt[3]  = '{16'hFA00, 4'h0, 4'h0, 4'h0, 1'b1, 2, 8'h77, 4'hB};
        vt[4]  = '{16'hFA00, 4'h0, 4'h0, 4'h0, 1'b1, 3, 8'h71, 4'h7};
        vt[5]  = '{16'hFA00, 4'h0, 4'h0, 4'h0, 1'b0, 2, 8'h00, 4'hB};
        vt[6]  = '{16'hFA00, 4'h0, 4'h0, 4'h0, 1'b0, 3, 8'h00, 4'h7};
        vt[7]  = '{16'hFA00, 4'h1, 4'h0, 4'h0, 1'b0, 0, 8'hBF, 4'hE};
        vt[8]  = '{16'h4321, 4'h0, 4'h2, 4'h0, 1'b0, 1, 8'h00, 4'hF};
        vt[9]  = '{16'h0E00, 4'h0, 4'h0, 4'h0, 1'b1, 2, 8'h79, 4'hB};
        vt[10] = '{16'h9000, 4'h0, 4'h0, 4'h0, 1'b0, 3, 8'h6F, 4'h7};
        vt[11] = '{16'h0A00, 4'h4, 4'h0, 4'h0, 1'b0, 2, 8'h80, 4'hB};
        vt[12] = '{16'h0300, 4'h0, 4'h0, 4'h4, 1'b0, 2, 8'h4F, 4'hB};
        vt[13] = '{16'h00C0, 4'h0, 4'h0, 4'h0, 1'b1, 1, 8'h39, 4'hD};

        @(negedge CLK);
        do_reset();

        for (int v = 0; v < 14; v++) begin
            data = vt[v].data; dp = vt[v].dp; blank = vt[v].blank;
            blink = vt[v].blink; hex = vt[v].hex;
            do_reset();
            for (int j = 0; j < FL; j++) begin
                step();
                if (j == vt[v].dig * S + D) begin
                    chk($sformatf("vec%0d_seg", v), 32'(seg), 32'(vt[v].seg));
                    chk($sformatf("vec%0d_cs", v), 32'(cs), 32'(vt[v].cs));
                end
            end
        end

        // Scan order and frame period.
        data = 16'h4321; dp = 0; blank = 0; blink = 0; hex = 0;
        do_reset();
        for (int j = 0; j < 2 * FL + 1; j++) begin
            step();
            if (fp) fp_at.push_back(j);
        end
        chk("fp_count", 32'(fp_at.size()), 32'd3);
        if (fp_at.size() >= 2)
            chk("fp_period", 32'(fp_at[1] - fp_at[0]), 32'(FL));

        // Blink: two frames lit, two frames dark.
        data = 16'h0300; blink = 4'b0100;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            cnt = 0;
            for (int j = 0; j < FL; j++) begin
                step();
                if (cs == 4'b1011) cnt++;
            end
            chk($sformatf("blink_f%0d", f), 32'(cnt),
                ((f / 2) % 2 == 0) ? 32'(S - D) : 32'd0);
        end
        blink = 0;

        // Blank: digit1 is never selected.
        blank = 4'b0010;
        do_reset();
        cnt = 0;
        for (int j = 0; j < 4 * FL; j++) begin
            step();
            if (cs == 4'b1101) cnt++;
        end
        chk("blank_d1", 32'(cnt), 32'd0);
        blank = 0;

        // Snapshot coherence across a mid-frame data change.
        data = 16'h1111;
        do_reset();
        cnt = 0; bad = 0;
        for (int j = 0; j < 2 * FL; j++) begin
            step();
            if (j == 10) data = 16'h2222;
            if (cs != 4'hF) begin
                if (j < FL && seg != 8'h06) cnt++;
                if (j >= FL && seg != 8'h5B) bad++;
            end
        end
        chk("snap_old_frame", 32'(cnt), 32'd0);
        chk("snap_new_frame", 32'(bad), 32'd0);

        // Reset in the middle of slot 2.
        data = 16'h4321;
        do_reset();
        for (int j = 0; j < 2 * S + 3; j++) step();
        RST = 1'b1;
        step();
        chk("rst_mid_cs", 32'(cs), 32'hF);
        chk("rst_mid_seg", 32'(seg), 32'h00);
        RST = 1'b0;
        step();
        chk("rst_fp", 32'(fp), 32'd1);
        chk("rst_dead_cs", 32'(cs), 32'hF);
        for (int j = 1; j <= D; j++) step();
        chk("rst_restart_cs", 32'(cs), 32'hE);
        chk("rst_restart_seg", 32'(seg), 32'h06);

        // Randomized inputs with random hold times.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            data = 16'($urandom);
            dp = 4'($urandom); blank = 4'($urandom);
            blink = 4'($urandom); hex = 1'($urandom);
            if (r % 10 == 9) begin
                blank = 0; do_reset();
            end
            for (int j = $urandom_range(1, 50); j > 0; j--) step();
        end

        // Single digit, no dead time, two-cycle slots.
        @(posedge CLK);
        @(negedge CLK);
        chk("sw_reset_cs", 32'(cs2), 32'd1);
        chk("sw_reset_fp", 32'(fp2), 32'd0);
        RST2 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("sw_cs", 32'(cs2), 32'd0);
            chk("sw_seg", 32'(seg2), 32'h6D);
            chk("sw_fp", 32'(fp2), (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
